// File: rtl/sram_pkg.sv
// Shared widths, sweep value and controller state encoding for the
// 41x512 byte-masked SRAM port controller.
package sram_pkg;

  localparam int DATA_W = 41;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int WEN_W  = 5;

  localparam logic [DATA_W-1:0] INIT_VALUE = 41'd0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sram_41_512_port_ctrl.sv
// Requester-side controller for the 41x512 SRAM: clear sweep after reset/flush,
// request stream to SRAM write/read accesses, registered read response channel.
module sram_41_512_port_ctrl
  import sram_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_adr_i,
  input  logic [WEN_W-1:0]  req_wen_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  input  logic              flush_i,
  output logic              busy_o,
  output logic [WEN_W-1:0]  sram_wen_o,
  output logic [DATA_W-1:0] sram_data_o,
  output logic [ADDR_W-1:0] sram_wadr_o,
  output logic [ADDR_W-1:0] sram_radr_o,
  input  logic [DATA_W-1:0] sram_data_i
);

  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

  state_e              r_state;
  state_e              w_next_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;

  logic                w_ready;
  logic                w_busy;
  logic                w_rd_accept;
  logic [WEN_W-1:0]    w_wen;
  logic [ADDR_W-1:0]   w_wadr;
  logic [DATA_W-1:0]   w_wdata;

  // Next-state and SRAM port drive; the sweep owns the write port in ST_INIT.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    w_wen        = {WEN_W{1'b0}};
    w_wadr       = req_adr_i;
    w_wdata      = req_data_i;
    case (r_state)
      ST_INIT: begin
        w_busy  = 1'b1;
        w_wen   = {WEN_W{1'b1}};
        w_wadr  = r_cnt;
        w_wdata = INIT_VALUE;
        if (r_cnt == LAST_ADR) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_INIT;
        end
      end
      ST_RUN: begin
        // A flush cycle refuses the request so nothing lands during the sweep start.
        w_ready = (~r_resp_valid | resp_ready_i) & ~flush_i;
        if (flush_i) begin
          w_next_state = ST_INIT;
        end else begin
          w_next_state = ST_RUN;
        end
        if (w_ready & req_valid_i & req_write_i) begin
          w_wen = req_wen_i;
        end else begin
          w_wen = {WEN_W{1'b0}};
        end
      end
      default: begin
        w_next_state = ST_INIT;
      end
    endcase
  end

  assign req_ready_o  = w_ready & ~rst_i;
  assign sram_wen_o   = w_wen & {WEN_W{~rst_i}};
  assign sram_wadr_o  = w_wadr;
  assign sram_data_o  = w_wdata;
  assign sram_radr_o  = req_adr_i;
  assign busy_o       = w_busy;
  assign resp_valid_o = r_resp_valid;
  assign resp_data_o  = r_resp_data;
  assign w_rd_accept  = req_ready_o & req_valid_i & ~req_write_i;

  // State register and sweep counter; the counter rests at zero outside the sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_INIT;
      r_cnt   <= {ADDR_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= {ADDR_W{1'b0}};
      end
    end
  end

  // Response register: captured on read accept, held until consumed, even across a sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= {DATA_W{1'b0}};
    end else if (w_rd_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_data  <= sram_data_i;
    end else if (r_resp_valid & resp_ready_i) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= r_resp_data;
    end else begin
      r_resp_valid <= r_resp_valid;
      r_resp_data  <= r_resp_data;
    end
  end

endmodule

// File: tb/tb_sram_41_512_port_ctrl.sv
// Randomized plus directed bench for sram_41_512_port_ctrl with an SRAM
// environment model and a transaction-level reference model.
module tb_sram_41_512_port_ctrl;

  localparam int DW = 41;
  localparam int AW = 9;
  localparam int ND = 512;
  localparam int WW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i, req_valid_i, req_ready_o, req_write_i;
  logic [AW-1:0] req_adr_i;
  logic [WW-1:0] req_wen_i;
  logic [DW-1:0] req_data_i;
  logic          resp_valid_o, resp_ready_i;
  logic [DW-1:0] resp_data_o;
  logic          flush_i, busy_o;
  logic [WW-1:0] sram_wen_o;
  logic [DW-1:0] sram_data_o;
  logic [AW-1:0] sram_wadr_o, sram_radr_o;
  logic [DW-1:0] sram_data_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  sram_41_512_port_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_adr_i(req_adr_i), .req_wen_i(req_wen_i), .req_data_i(req_data_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
    .flush_i(flush_i), .busy_o(busy_o),
    .sram_wen_o(sram_wen_o), .sram_data_o(sram_data_o), .sram_wadr_o(sram_wadr_o),
    .sram_radr_o(sram_radr_o), .sram_data_i(sram_data_i)
  );

  // Byte lane owning a data bit: lanes 0..3 are bytes, lane 4 also owns the flag bit 40.
  function automatic int lane_of(input int b);
    return (b / 8 > 4) ? 4 : b / 8;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                          input logic [WW-1:0] wen);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < DW; b++) if (wen[lane_of(b)]) r[b] = new_v[b];
    return r;
  endfunction

  // Environment SRAM driven purely by the DUT's port outputs.
  logic [DW-1:0] sram_mem [0:ND-1];
  assign sram_data_i = sram_mem[sram_radr_o];
  always @(posedge clk_i) begin
    if (sram_wen_o != 5'b00000) sram_mem[sram_wadr_o] <= merge(sram_mem[sram_wadr_o], sram_data_o, sram_wen_o);
  end

  // Reference model state
  logic [DW-1:0] exp_mem [0:ND-1];
  bit            m_known = 1'b0;
  bit            m_busy;
  int            m_cnt;
  bit            m_rv;
  logic [DW-1:0] m_rd;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic w, input logic [AW-1:0] adr,
                      input logic [WW-1:0] wen, input logic [DW-1:0] d, input logic rr, input logic fl);
    logic          exp_ready, acc;
    logic [WW-1:0] exp_wen;
    @(negedge clk_i);
    rst_i = rst; req_valid_i = v; req_write_i = w; req_adr_i = adr;
    req_wen_i = wen; req_data_i = d; resp_ready_i = rr; flush_i = fl;
    #1;
    exp_ready = !rst && m_known && !m_busy && (!m_rv || rr) && !fl;
    acc       = exp_ready && v;
    if (m_known) begin
      exp_wen = rst ? 5'b00000 : (m_busy ? 5'b11111 : ((acc && w) ? wen : 5'b00000));
      check_val("req_ready", {40'd0, req_ready_o}, {40'd0, exp_ready});
      check_val("busy", {40'd0, busy_o}, {40'd0, m_busy});
      check_val("sram_wen", {36'd0, sram_wen_o}, {36'd0, exp_wen});
      if (m_busy && !rst) begin
        check_val("sweep_wadr", {32'd0, sram_wadr_o}, DW'(m_cnt));
        check_val("sweep_data", sram_data_o, 41'd0);
      end
      if (acc && w) begin
        check_val("wr_adr", {32'd0, sram_wadr_o}, {32'd0, adr});
        check_val("wr_data", sram_data_o, d);
      end
      if (acc && !w) check_val("rd_adr", {32'd0, sram_radr_o}, {32'd0, adr});
      check_val("resp_valid", {40'd0, resp_valid_o}, {40'd0, m_rv});
      if (m_rv) check_val("resp_data", resp_data_o, m_rd);
    end
    @(posedge clk_i);
    if (rst) begin
      m_known = 1'b1; m_busy = 1'b1; m_cnt = 0; m_rv = 1'b0; m_rd = '0;
    end else begin
      if (acc && !w) begin
        m_rv = 1'b1; m_rd = exp_mem[adr];
      end else if (m_rv && rr) begin
        m_rv = 1'b0;
      end
      if (acc && w) exp_mem[adr] = merge(exp_mem[adr], d, wen);
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == ND) begin
          m_busy = 1'b0; m_cnt = 0;
          for (int i = 0; i < ND; i++) exp_mem[i] = '0;
        end
      end else if (fl) begin
        m_busy = 1'b1; m_cnt = 0;
      end
    end
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 9'd0, 5'd0, 41'd0, rr, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WW-1:0] wen, input logic [DW-1:0] d);
    step(1'b0, 1'b1, 1'b1, a, wen, d, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic rr);
    step(1'b0, 1'b1, 1'b0, a, 5'd0, 41'd0, rr, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_adr_i = '0;
    req_wen_i = '0; req_data_i = '0; resp_ready_i = 1'b1; flush_i = 1'b0;

    step(1'b1, 1'b0, 1'b0, 9'd0, 5'd0, 41'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 9'd0, 5'd0, 41'd0, 1'b1, 1'b0);
    check_val("reset_resp_data", resp_data_o, 41'd0);
    idle(ND + 2, 1'b1);

    // Full write, read back, partial writes incl. flag lane
    wr(9'h005, 5'b11111, 41'h1_AABBCCDDEE);
    rd(9'h005, 1'b1);
    idle(1, 1'b0);
    check_val("rd_adr5_full", resp_data_o, 41'h1_AABBCCDDEE);
    idle(1, 1'b1);
    wr(9'h005, 5'b00010, 41'h0_0000001100);
    rd(9'h005, 1'b1);
    wr(9'h005, 5'b10000, 41'h0_0000000000);
    rd(9'h005, 1'b1);
    wr(9'h007, 5'b00000, 41'h1_FFFFFFFFFF);
    rd(9'h007, 1'b1);
    wr(9'h001, 5'b11111, 41'h0_0101010101);
    wr(9'h002, 5'b11111, 41'h1_0202020202);
    wr(9'h003, 5'b11111, 41'h0_0303030303);
    rd(9'h001, 1'b1); rd(9'h002, 1'b1); rd(9'h003, 1'b1);
    idle(1, 1'b1);

    // Back-pressure: response held, requests refused
    rd(9'h002, 1'b0);
    for (int i = 0; i < 3; i++) rd(9'h003, 1'b0);
    rd(9'h003, 1'b1);
    idle(2, 1'b1);

    // Flush with a pending, unconsumed response
    rd(9'h005, 1'b0);
    step(1'b0, 1'b0, 1'b0, 9'd0, 5'd0, 41'd0, 1'b0, 1'b1);
    idle(4, 1'b0);
    idle(ND + 2, 1'b1);
    rd(9'h005, 1'b1);
    idle(1, 1'b1);

    // Reset mid-sweep at address 200, then flush pulses during INIT
    step(1'b0, 1'b0, 1'b0, 9'd0, 5'd0, 41'd0, 1'b1, 1'b1);
    idle(200, 1'b1);
    step(1'b1, 1'b0, 1'b0, 9'd0, 5'd0, 41'd0, 1'b1, 1'b0);
    idle(100, 1'b1);
    step(1'b0, 1'b0, 1'b0, 9'd0, 5'd0, 41'd0, 1'b1, 1'b1);
    idle(300, 1'b1);
    step(1'b0, 1'b0, 1'b0, 9'd0, 5'd0, 41'd0, 1'b1, 1'b1);
    idle(ND, 1'b1);

    // Randomized traffic on a small address window
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           9'($urandom_range(0, 15)),
           5'($urandom),
           {9'($urandom), 32'($urandom)},
           1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
